// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing XOR checksum byte (CHK state).
package program_loader_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;
  localparam int         LOADER_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CHK  = 3'd4,
`endif
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler: the word is presented combinationally on the
// cycle its last byte arrives, so the owner can register it alongside the write.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(LOADER_WORD_BYTES - 1);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = (cnt_q == LAST_BYTE) ? 2'd0 : cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_out   = {shift_q, byte_in};
  assign word_valid = byte_valid && !clear && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Serial program loader: handshake byte, 32-bit big-endian word count, then N words
// written to instruction memory. LOADER_CHECKSUM_EN appends an XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         IMEM_ADDR_W = 15,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef logic [IMEM_ADDR_W:0] cnt_t;

  localparam logic [32:0] MAX_WORDS = 33'(1) << IMEM_ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                 state_q, state_d;
  cnt_t                   word_cnt_q, word_cnt_d;
  cnt_t                   len_q, len_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]            imem_wdata_q, imem_wdata_d;
  logic                   tx_start_q, tx_start_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic        idle_like;
  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic        asm_word_valid;
  logic        byte_bad;

  assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign asm_clear = idle_like && start;
  // Framing-errored bytes never reach the assembler, so no partial word can complete.
  assign asm_valid = rx_ready && !rx_ferr && ((state_q == LEN) || (state_q == DATA));
  assign byte_bad  = rx_ready && rx_ferr;

  word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word_out   (asm_word),
    .word_valid (asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    tx_start_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = SYNC;
          word_cnt_d = '0;
          len_d      = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      SYNC: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = LEN;
        end
      end
      LEN: begin
        if (byte_bad) begin
          state_d = ERR;
        end else if (asm_word_valid) begin
          len_d = asm_word[IMEM_ADDR_W:0];
          if (asm_word == 32'd0)
            state_d = AFTER_DATA;
          else if ({1'b0, asm_word} > MAX_WORDS)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (byte_bad) begin
          state_d = ERR;
        end else if (asm_valid) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
          if (asm_word_valid) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[IMEM_ADDR_W-1:0];
            imem_wdata_d = asm_word;
            word_cnt_d   = word_cnt_q + cnt_t'(1);
            if (word_cnt_d == len_q)
              state_d = AFTER_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_bad)
          state_d = ERR;
        else if (rx_ready)
          state_d = (rx_data == xor_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      len_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      tx_start_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      tx_start_q   <= tx_start_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign tx_data    = SYNC_BYTE;
  assign tx_start   = tx_start_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
  assign busy       = (state_q == SYNC) || (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
`else
  assign busy       = (state_q == SYNC) || (state_q == LEN) || (state_q == DATA);
`endif
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: handshake, loads, length limits, framing
// errors, reset mid-word and (with LOADER_CHECKSUM_EN) the checksum byte.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_ferr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        imem_we;
  logic [14:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;
  int tx_pulses = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [14:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  program_loader #(.IMEM_ADDR_W(15), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (tx_start) begin
      tx_pulses++;
      tx_last = tx_data;
    end
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      $display("write addr=%0h data=%08h", imem_addr, imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wr_addr(input int i);
    return (wr_addr_q.size() > i) ? 64'(wr_addr_q[i]) : 'x;
  endfunction

  function automatic logic [63:0] wr_data(input int i);
    return (wr_data_q.size() > i) ? 64'(wr_data_q[i]) : 'x;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_data = b; rx_ferr = fe; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rx_ferr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'hAA);
    rstn = 1'b1;
    @(negedge clk);

    // handshake held off by a busy transmitter
    tx_busy = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("sync_wait_no_tx", 64'(tx_pulses), 64'd0);
    check("sync_wait_busy", 64'(busy), 64'd1);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("sync_one_pulse", 64'(tx_pulses), 64'd1);
    check("sync_byte", 64'(tx_last), 64'hAA);

    // start during LEN ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_ignored_tx", 64'(tx_pulses), 64'd1);

    // two-word load
    clear_log();
    send_word(32'h0000_0002);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    @(negedge clk);
    check("load2_count", 64'(wr_addr_q.size()), 64'd2);
    check("load2_addr0", wr_addr(0), 64'h0);
    check("load2_data0", wr_data(0), 64'h1234_5678);
    check("load2_addr1", wr_addr(1), 64'h1);
    check("load2_data1", wr_data(1), 64'h9ABC_DEF0);
    check("load2_done", 64'(done), 64'd1);
    check("load2_busy", 64'(busy), 64'd0);
    check("load2_err", 64'(err), 64'd0);

    // zero-length load, starting from DONE
    clear_log();
    start_load();
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_done_cleared", 64'(done), 64'd0);
    send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_no_write", 64'(wr_addr_q.size()), 64'd0);

    // length one past the memory size
    clear_log();
    start_load();
    send_word(32'h0000_8001);
    @(negedge clk);
    check("oversize_err", 64'(err), 64'd1);
    check("oversize_busy", 64'(busy), 64'd0);
    send_word(32'h0102_0304);
    check("oversize_no_write", 64'(wr_addr_q.size()), 64'd0);

    // framing error on the third data byte, starting from ERR
    clear_log();
    start_load();
    check("ferr_err_cleared", 64'(err), 64'd0);
    send_word(32'h0000_0001);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("ferr_err", 64'(err), 64'd1);
    send_byte(8'h44, 1'b0);
    @(negedge clk);
    check("ferr_no_write", 64'(wr_addr_q.size()), 64'd0);

    // reset in the middle of a word
    clear_log();
    start_load();
    send_word(32'h0000_0001);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    @(negedge clk);
    check("midrst_no_write", 64'(wr_addr_q.size()), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // checksum of 01^02^03^04 = 04
    clear_log();
    start_load();
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    send_byte(8'h04, 1'b0);
    check("chk_ok_done", 64'(done), 64'd1);
    check("chk_ok_write", wr_data(0), 64'h0102_0304);
    clear_log();
    start_load();
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    send_byte(8'h05, 1'b0);
    check("chk_bad_err", 64'(err), 64'd1);
    check("chk_bad_write", wr_data(0), 64'h0102_0304);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IMEM_ADDR_W, default 15, instruction-memory word-address width.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hAA, handshake byte sent to the host.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  one-cycle load request
- rx_data  in  8  received byte
- rx_ready  in  1  rx_data valid, one cycle
- rx_ferr  in  1  framing error, qualified by rx_ready
- tx_data  out  8  byte to transmitter
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- imem_we  out  1  instruction write strobe
- imem_addr  out  IMEM_ADDR_W  word address
- imem_wdata  out  32  instruction word
- busy  out  1  load in progress
- done  out  1  load completed
- err  out  1  load aborted

Function
REQ-005 SHALL implement states IDLE, SYNC, LEN, DATA, CHK, DONE and ERR.
REQ-006 IDLE: start=1 SHALL go to SYNC and clear done, err, the byte counter and the word counter; start in any other state SHALL be ignored.
REQ-007 SYNC: when tx_busy=0, SHALL assert tx_start for exactly one cycle with tx_data=SYNC_BYTE, then go to LEN; tx_data SHALL hold SYNC_BYTE at all other times.
REQ-008 SYNC: rx_ready SHALL be ignored.
REQ-009 LEN: SHALL assemble 4 bytes big-endian (first byte = bits 31:24) into word count N.
REQ-010 LEN: N=0 SHALL go to CHK if LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-011 LEN: N>2**IMEM_ADDR_W SHALL go to ERR.
REQ-012 LEN: any other N SHALL go to DATA.
REQ-013 DATA: SHALL assemble big-endian words; the cycle after the rx_ready of each word's 4th byte, imem_we=1 for one cycle with imem_addr=word index (0..N-1) and imem_wdata=the word.
REQ-014 DATA: after word N-1 is written, SHALL go to CHK if LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-015 In LEN, DATA and CHK, rx_ready with rx_ferr=1 SHALL go to ERR, discard the byte and generate no write.
REQ-016 DONE and ERR SHALL each hold their output until the next start, then behave as IDLE.
REQ-017 busy SHALL be 1 in SYNC, LEN, DATA and CHK and 0 elsewhere; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-018 Word and byte counters SHALL be IMEM_ADDR_W+1 and 2 bits wide and SHALL never wrap within a legal load.
REQ-019 rx_ready in IDLE, DONE or ERR SHALL be dropped.

Reset
REQ-020 On rstn=0, SHALL go to IDLE immediately.
REQ-021 On rstn=0, tx_start, imem_we, busy, done and err SHALL be 0, imem_addr and imem_wdata SHALL be 0, and all counters SHALL be 0.
REQ-022 Reset during any state, including mid-word, SHALL discard the partial word and generate no further imem_we.

Configuration
REQ-023 With LOADER_CHECKSUM_EN defined, CHK SHALL take one byte and compare it to the XOR of all 4N data bytes (LEN bytes excluded): match goes to DONE, mismatch goes to ERR.
REQ-024 Without LOADER_CHECKSUM_EN, the CHK state and the XOR register SHALL be absent and the load SHALL end directly in DONE.

Structure
REQ-025 The state enum, the default SYNC_BYTE and LOADER_WORD_BYTES=4 SHALL live in the shared constant package.
REQ-026 Byte-to-word assembly SHALL be one sub-module, word_assembler: 8-bit in, 32-bit out, word-valid pulse, clear input.

Verification
REQ-027 start with tx_busy=1 for 5 cycles -> no tx_start until tx_busy=0, then one tx_start pulse with tx_data=8'hAA.
REQ-028 Bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> writes addr0=32'h12345678 and addr1=32'h9ABCDEF0, then done=1 and busy=0.
REQ-029 Length 00 00 00 00 -> no imem_we, then done=1 (with LOADER_CHECKSUM_EN, after checksum byte 00).
REQ-030 Length 0x00008001 with IMEM_ADDR_W=15 -> err=1 and no imem_we.
REQ-031 rx_ferr on the 3rd data byte -> err=1, and the first word is not written.
REQ-032 With LOADER_CHECKSUM_EN, N=1, word 01 02 03 04, checksum 04 -> done=1; checksum 05 -> err=1, with the write still performed.
